// File: rtl/serial_rx_sequencer.sv
// Serial frame receiver: start bit, port address, payload length, payload routed to a one-hot port.
// Optional even-parity check over the payload is compiled in with `define PARITY_CHECK_EN.
module serial_rx_sequencer #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic                 SerIn,
  output logic                 SerOut,
  output logic                 SerOutValid,
  output logic [2**ADDR_W-1:0] PortEn,
  output logic                 Busy,
  output logic                 Done,
  output logic                 ParErr
);

  localparam int NPORT = 2**ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    DONE
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  acnt_q;
  logic [LEN_W-1:0]   lcnt_q;
  logic [LEN_W-1:0]   dcnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic [NPORT-1:0]   porten_q;
  logic [ADDR_W-1:0]  addr_d;
  logic [LEN_W-1:0]   len_d;
`ifdef PARITY_CHECK_EN
  logic               par_q;
  logic               perr_q;
`endif

  function automatic logic [NPORT-1:0] onehot(input logic [ADDR_W-1:0] a);
    return NPORT'(1) << a;
  endfunction

  // MSB-first shift: the newest bit enters at the LSB.
  assign addr_d = (addr_q << 1) | ADDR_W'(SerIn);
  assign len_d  = (len_q << 1) | LEN_W'(SerIn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acnt_q   <= '0;
      lcnt_q   <= '0;
      dcnt_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      porten_q <= '0;
`ifdef PARITY_CHECK_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else if (clkEn) begin
      valid_q  <= 1'b0;
      porten_q <= '0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!SerIn) begin
            state_q <= ADDR;
            acnt_q  <= ADDR_W'(ADDR_W - 1);
            busy_q  <= 1'b1;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
          end
        end
        ADDR: begin
          addr_q <= addr_d;
          if (acnt_q == '0) begin
            state_q <= LEN;
            lcnt_q  <= LEN_W'(LEN_W - 1);
          end else begin
            acnt_q <= acnt_q - 1'b1;
          end
        end
        LEN: begin
          len_q <= len_d;
          if (lcnt_q == '0) begin
            if (len_d != '0) begin
              state_q  <= DATA;
              dcnt_q   <= len_d;
              valid_q  <= 1'b1;
              porten_q <= onehot(addr_q);
            end else begin
`ifdef PARITY_CHECK_EN
              state_q <= PARITY;
`else
              state_q <= DONE;
              done_q  <= 1'b1;
`endif
            end
          end else begin
            lcnt_q <= lcnt_q - 1'b1;
          end
        end
        DATA: begin
`ifdef PARITY_CHECK_EN
          par_q <= par_q ^ SerIn;
`endif
          dcnt_q <= dcnt_q - 1'b1;
          if (dcnt_q == LEN_W'(1)) begin
`ifdef PARITY_CHECK_EN
            state_q <= PARITY;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            valid_q  <= 1'b1;
            porten_q <= porten_q;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          // Even parity: the parity bit must equal the XOR of the payload bits.
          perr_q  <= SerIn ^ par_q;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
          perr_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SerOut      = valid_q & SerIn;
  assign SerOutValid = valid_q;
  assign PortEn      = porten_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
`ifdef PARITY_CHECK_EN
  assign ParErr      = perr_q;
`else
  assign ParErr      = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Self-checking bench for serial_rx_sequencer: directed vector tables, hand-written
// reset/stall sequences and randomized frames checked against a frame-level model.
module tb_serial_rx_sequencer;

  localparam int A  = 2;
  localparam int L  = 4;
  localparam int NP = 4;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clkEn = 1'b0;
  logic          SerIn = 1'b1;
  logic          SerOut, SerOutValid, Busy, Done, ParErr;
  logic [NP-1:0] PortEn;

  int n_chk  = 0;
  int n_fail = 0;

  serial_rx_sequencer #(.ADDR_W(A), .LEN_W(L)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(SerIn),
    .SerOut(SerOut), .SerOutValid(SerOutValid), .PortEn(PortEn),
    .Busy(Busy), .Done(Done), .ParErr(ParErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic          sin;
    logic          vld;
    logic [NP-1:0] pe;
    logic          busy;
    logic          done;
    logic          perr;
  } slot_t;

  typedef struct {
    logic          en;
    logic          sin;
    logic          so;
    logic          vld;
    logic [NP-1:0] pe;
    logic          busy;
    logic          done;
    logic          perr;
  } vec_t;

  vec_t  tbl[$];
  slot_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic so, input logic vld,
                            input logic [NP-1:0] pe, input logic busy,
                            input logic done, input logic perr);
    chk({tag, ".SerOut"}, 32'(SerOut), 32'(so));
    chk({tag, ".SerOutValid"}, 32'(SerOutValid), 32'(vld));
    chk({tag, ".PortEn"}, 32'(PortEn), 32'(pe));
    chk({tag, ".Busy"}, 32'(Busy), 32'(busy));
    chk({tag, ".Done"}, 32'(Done), 32'(done));
    chk({tag, ".ParErr"}, 32'(ParErr), 32'(perr));
  endtask

  task automatic cyc(input logic r, input logic en, input logic s);
    @(posedge clk);
    #1;
    rst = r;
    clkEn = en;
    SerIn = s;
    @(negedge clk);
  endtask

  function automatic vec_t v(input logic en, input logic sin, input logic so, input logic vld,
                             input logic [NP-1:0] pe, input logic busy, input logic done,
                             input logic perr);
    vec_t r;
    r.en = en; r.sin = sin; r.so = so; r.vld = vld;
    r.pe = pe; r.busy = busy; r.done = done; r.perr = perr;
    return r;
  endfunction

  function automatic slot_t mk(input logic sin, input logic vld, input logic [NP-1:0] pe,
                               input logic busy, input logic done, input logic perr);
    slot_t s;
    s.sin = sin; s.vld = vld; s.pe = pe; s.busy = busy; s.done = done; s.perr = perr;
    return s;
  endfunction

  task automatic idle_slots(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      check_outs("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Model: a frame is a list of enabled-cycle slots, each with the bit driven and the
  // outputs the receiver shows during that cycle. Stall cycles repeat a slot's outputs.
  task automatic run_frame(input int addr, input int n, input logic [31:0] pay,
                           input bit flip, input int stall_pct, input int st_slot,
                           input int st_n, output int nvld, output int ndone);
    logic          par;
    logic [NP-1:0] pe;
    logic          s;
    int            stalls;
    q.delete();
    pe = NP'(1) << addr;
    par = 1'b0;
    q.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    for (int i = A - 1; i >= 0; i--) q.push_back(mk(1'((addr >> i) & 1), 1'b0, '0, 1'b1, 1'b0, 1'b0));
    for (int i = L - 1; i >= 0; i--) q.push_back(mk(1'((n >> i) & 1), 1'b0, '0, 1'b1, 1'b0, 1'b0));
    for (int j = 0; j < n; j++) begin
      q.push_back(mk(pay[n-1-j], 1'b1, pe, 1'b1, 1'b0, 1'b0));
      par = par ^ pay[n-1-j];
    end
    if (PAR) q.push_back(mk(par ^ flip, 1'b0, '0, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'($urandom_range(1)), 1'b0, '0, 1'b1, 1'b1, PAR & flip));
    nvld = 0;
    ndone = 0;
    for (int idx = 0; idx < q.size(); idx++) begin
      if (idx == st_slot) stalls = st_n;
      else stalls = ($urandom_range(99) < stall_pct) ? int'($urandom_range(2, 1)) : 0;
      for (int k = 0; k < stalls; k++) begin
        s = 1'($urandom_range(1));
        cyc(1'b1, 1'b0, s);
        check_outs("stall", q[idx].vld & s, q[idx].vld, q[idx].pe, q[idx].busy,
                   q[idx].done, q[idx].perr);
      end
      cyc(1'b1, 1'b1, q[idx].sin);
      check_outs("slot", q[idx].vld & q[idx].sin, q[idx].vld, q[idx].pe, q[idx].busy,
                 q[idx].done, q[idx].perr);
      if (SerOutValid === 1'b1) nvld++;
      if (Done === 1'b1) ndone++;
    end
  endtask

  initial begin
    int nv, nd, nv2, nd2;
    // Asynchronous reset state before any clock edge.
    #1;
    check_outs("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

`ifndef PARITY_CHECK_EN
    // Frame 0,10,0011,101 then frame 0,01,0000.
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 1, 4'b0100, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 4'b0100, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 1, 4'b0100, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'b0000, 0, 0, 0));
`else
    // Frame 0,11,0010,11 with parity bit 1 (mismatch), then with parity bit 0.
    for (int f = 0; f < 2; f++) begin
      tbl.push_back(v(1, 0, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(v(1, 1, 1, 1, 4'b1000, 1, 0, 0));
      tbl.push_back(v(1, 1, 1, 1, 4'b1000, 1, 0, 0));
      tbl.push_back(v(1, f == 0, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 4'b0000, 1, 1, f == 0));
      tbl.push_back(v(1, 1, 0, 0, 4'b0000, 0, 0, 0));
    end
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(1'b1, tbl[i].en, tbl[i].sin);
      check_outs($sformatf("tbl%0d", i), tbl[i].so, tbl[i].vld, tbl[i].pe,
                 tbl[i].busy, tbl[i].done, tbl[i].perr);
    end

    // Two-cycle stall after the second payload bit of the 0,10,0011,101 frame.
    run_frame(2, 3, 32'b101, 1'b0, 0, 1 + A + L + 2, 2, nv, nd);
    chk("stall.valid_count", 32'(nv), 32'd3);
    chk("stall.done_count", 32'(nd), 32'd1);
    idle_slots(1);

    // Reset in the middle of the payload.
    cyc(1, 1, 0); cyc(1, 1, 1); cyc(1, 1, 0);
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 1); cyc(1, 1, 1);
    cyc(1, 1, 1);
    @(posedge clk);
    #1 SerIn = 1'b1;
    #2 chk("midreset.pre_valid", 32'(SerOutValid), 32'd1);
    rst = 1'b0;
    #1 check_outs("midreset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      check_outs("postreset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end

    // Back-to-back maximum-length frames.
    run_frame(1, 15, 32'($urandom), 1'b0, 0, -1, 0, nv, nd);
    run_frame(3, 15, 32'($urandom), 1'b1, 0, -1, 0, nv2, nd2);
    chk("b2b.valid1", 32'(nv), 32'd15);
    chk("b2b.done1", 32'(nd), 32'd1);
    chk("b2b.valid2", 32'(nv2), 32'd15);
    chk("b2b.done2", 32'(nd2), 32'd1);
    idle_slots(1);

    // Randomized frames with random stalls and idle gaps.
    for (int f = 0; f < 40; f++) begin
      run_frame(int'($urandom_range(NP - 1)), int'($urandom_range(15)), 32'($urandom),
                1'($urandom_range(1)), 20, -1, 0, nv, nd);
      chk("rand.done_count", 32'(nd), 32'd1);
      idle_slots(int'($urandom_range(2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
